// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin share of one fixed-latency sequential multiplier between two requesters
//
// Latches the winning requester's operands and pulses the multiplier start.
// Waits a fixed number of cycles, then captures the product tagged with the requester id.
// Every output is driven straight from a register.
//
// Ports
//   clock, reset            rising-edge clock; asynchronous active-high reset
//   req0/req1               request levels, held until the matching grant
//   a0/b0, a1/b1            8-bit operands of requester 0 / 1
//   gnt0/gnt1               one-cycle grant pulse (operands already latched)
//   mult_start              one-cycle start pulse to the multiplier
//   mult_multiplier/_multiplicand  latched operands, held until the next latch
//   mult_sign/_zflag/_result       multiplier outputs, sampled at capture
//   out_valid               one-cycle pulse when out_* are updated
//   out_id                  requester that owns out_*
//   out_result/_sign/_zflag captured product fields, held until the next capture
//   busy                    high in every state except IDLE
module mult_share_arbiter #(
    parameter int MULT_LATENCY = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        mult_start,
    output logic [7:0]  mult_multiplier,
    output logic [7:0]  mult_multiplicand,
    input  logic        mult_sign,
    input  logic        mult_zflag,
    input  logic [13:0] mult_result,
    output logic        out_valid,
    output logic        out_id,
    output logic [13:0] out_result,
    output logic        out_sign,
    output logic        out_zflag,
    output logic        busy
);
    // The counter only has to hold MULT_LATENCY-1.
    localparam int CW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_id, w_id_nxt;
    logic          r_last, w_last_nxt;
    logic [7:0]    r_mult_a, w_mult_a_nxt;
    logic [7:0]    r_mult_b, w_mult_b_nxt;
    logic          r_start, w_start_nxt;
    logic          r_gnt0, w_gnt0_nxt;
    logic          r_gnt1, w_gnt1_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_busy;
    logic          w_cap;
    logic          r_out_id;
    logic [13:0]   r_out_result;
    logic          r_out_sign;
    logic          r_out_zflag;
    logic          w_pick1;

    // On a tie, serve the requester that was not served last.
    assign w_pick1 = req1 & (~req0 | ~r_last);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_id_nxt     = r_id;
        w_last_nxt   = r_last;
        w_mult_a_nxt = r_mult_a;
        w_mult_b_nxt = r_mult_b;
        w_start_nxt  = 1'b0;
        w_gnt0_nxt   = 1'b0;
        w_gnt1_nxt   = 1'b0;
        w_valid_nxt  = 1'b0;
        w_cap        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 | req1) begin
                    w_state_nxt  = S_START;
                    w_id_nxt     = w_pick1;
                    w_mult_a_nxt = w_pick1 ? a1 : a0;
                    w_mult_b_nxt = w_pick1 ? b1 : b0;
                    w_start_nxt  = 1'b1;
                    w_gnt0_nxt   = ~w_pick1;
                    w_gnt1_nxt   = w_pick1;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = CNT_LOAD;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    w_cap       = 1'b1;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_last_nxt  = r_id;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_id     <= 1'b0;
            r_last   <= 1'b1;
            r_mult_a <= '0;
            r_mult_b <= '0;
            r_start  <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_id     <= w_id_nxt;
            r_last   <= w_last_nxt;
            r_mult_a <= w_mult_a_nxt;
            r_mult_b <= w_mult_b_nxt;
            r_start  <= w_start_nxt;
            r_gnt0   <= w_gnt0_nxt;
            r_gnt1   <= w_gnt1_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    // Result fields move only at capture and hold between captures.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_id     <= 1'b0;
            r_out_result <= '0;
            r_out_sign   <= 1'b0;
            r_out_zflag  <= 1'b0;
        end else if (w_cap) begin
            r_out_id     <= r_id;
            r_out_result <= mult_result;
            r_out_sign   <= mult_sign;
            r_out_zflag  <= mult_zflag;
        end
    end

    assign gnt0              = r_gnt0;
    assign gnt1              = r_gnt1;
    assign mult_start        = r_start;
    assign mult_multiplier   = r_mult_a;
    assign mult_multiplicand = r_mult_b;
    assign out_valid         = r_valid;
    assign out_id            = r_out_id;
    assign out_result        = r_out_result;
    assign out_sign          = r_out_sign;
    assign out_zflag         = r_out_zflag;
    assign busy              = r_busy;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed bench for mult_share_arbiter with behavioural fixed-latency multipliers
module tb_mult_share_arbiter;
    localparam int L = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, mult_start, out_valid, out_id, out_sign, out_zflag, busy;
    logic [7:0]  mult_multiplier, mult_multiplicand;
    logic        mult_sign, mult_zflag;
    logic [13:0] mult_result, out_result;

    logic        u1_gnt0, u1_gnt1, u1_start, u1_valid, u1_id, u1_osign, u1_ozflag, u1_busy;
    logic [7:0]  u1_ma, u1_mb;
    logic        u1_sign, u1_zflag;
    logic [13:0] u1_result, u1_oresult;

    int n_vec = 0;
    int n_err = 0;
    logic [13:0] prev_res = '0;

    always #5 clock = ~clock;

    // Sign-magnitude multiplier model; garbage is driven until the latency has elapsed.
    function automatic logic [15:0] mdl(input logic [7:0] x, input logic [7:0] y);
        logic [13:0] p;
        p = {7'b0, x[6:0]} * {7'b0, y[6:0]};
        return {x[7] ^ y[7], p == 14'd0, p};
    endfunction

    logic [3:0] mc = '0;
    always @(posedge clock) mc <= mult_start ? 4'(L - 1) : (mc != 0 ? mc - 4'd1 : mc);
    assign {mult_sign, mult_zflag, mult_result} =
        (mc == 0) ? mdl(mult_multiplier, mult_multiplicand) : {2'b11, 14'h2AAA};
    assign {u1_sign, u1_zflag, u1_result} = mdl(u1_ma, u1_mb);

    mult_share_arbiter #(.MULT_LATENCY(L)) dut (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .mult_start(mult_start),
        .mult_multiplier(mult_multiplier), .mult_multiplicand(mult_multiplicand),
        .mult_sign(mult_sign), .mult_zflag(mult_zflag), .mult_result(mult_result),
        .out_valid(out_valid), .out_id(out_id), .out_result(out_result),
        .out_sign(out_sign), .out_zflag(out_zflag), .busy(busy)
    );

    mult_share_arbiter #(.MULT_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(u1_gnt0), .gnt1(u1_gnt1), .mult_start(u1_start),
        .mult_multiplier(u1_ma), .mult_multiplicand(u1_mb),
        .mult_sign(u1_sign), .mult_zflag(u1_zflag), .mult_result(u1_result),
        .out_valid(u1_valid), .out_id(u1_id), .out_result(u1_oresult),
        .out_sign(u1_osign), .out_zflag(u1_ozflag), .busy(u1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {gnt0, gnt1, mult_start, out_valid, busy, out_id, out_sign, out_zflag}, 0);
        chk({tag, "_ops"}, {mult_multiplier, mult_multiplicand}, 0);
        chk({tag, "_res"}, out_result, 0);
    endtask

    // Called at a negedge; the pending request is sampled at the next posedge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1 chk_zero(tag);
        @(negedge clock);
        reset = 1'b0;
        prev_res = '0;
    endtask

    // Caller has set the request at the current negedge; ends on the IDLE negedge after DONE.
    task automatic expect_op(input string tag, input logic id, input logic [7:0] ea, input logic [7:0] eb,
                             input logic [13:0] er, input logic es, input logic ez,
                             input bit drop, input bit chg, input bit lat1);
        int k;
        int k1;
        logic [13:0] r1;
        k1 = 0;
        r1 = '0;
        @(negedge clock);
        k = 1;
        chk({tag, "_gnt"}, {busy, gnt1, gnt0, mult_start}, id ? 4'b1101 : 4'b1011);
        chk({tag, "_hold"}, out_result, prev_res);
        if (drop) begin
            if (id) req1 = 1'b0; else req0 = 1'b0;
        end
        if (chg) begin
            if (id) a1 = 8'd9; else a0 = 8'd9;
        end
        @(negedge clock);
        k = 2;
        chk({tag, "_pulse"}, {gnt1, gnt0, mult_start}, 0);
        while (!out_valid && k < 40) begin
            if (u1_valid && k1 == 0) begin k1 = k; r1 = u1_oresult; end
            @(negedge clock);
            k++;
        end
        chk({tag, "_lat"}, k, L + 2);
        chk({tag, "_id"}, out_id, id);
        chk({tag, "_result"}, out_result, er);
        chk({tag, "_flags"}, {out_sign, out_zflag, busy}, {es, ez, 1'b1});
        chk({tag, "_ops"}, {mult_multiplier, mult_multiplicand}, {ea, eb});
        if (lat1) begin
            chk({tag, "_l1_lat"}, k1, 3);
            chk({tag, "_l1_res"}, r1, er);
        end
        @(negedge clock);
        chk({tag, "_idle"}, {out_valid, busy}, 0);
        chk({tag, "_held"}, out_result, er);
        prev_res = er;
    endtask

    initial begin
        @(negedge clock);
        chk_zero("rst");
        do_reset("rst2");

        // Single requester, also checked on the latency-1 instance.
        req0 = 1'b1; a0 = 8'd3; b0 = 8'd10;
        expect_op("t1", 1'b0, 8'd3, 8'd10, 14'd30, 1'b0, 1'b0, 1, 0, 1);

        // Simultaneous requests after reset: req0 first, then req1 back to back.
        do_reset("t2rst");
        req0 = 1'b1; req1 = 1'b1; a1 = 8'd4; b1 = 8'd5;
        expect_op("t2a", 1'b0, 8'd3, 8'd10, 14'd30, 1'b0, 1'b0, 1, 0, 0);
        expect_op("t2b", 1'b1, 8'd4, 8'd5, 14'd20, 1'b0, 1'b0, 1, 0, 0);

        // Both held: alternation 0,1,0,1.
        req0 = 1'b1; req1 = 1'b1;
        expect_op("t3a", 1'b0, 8'd3, 8'd10, 14'd30, 1'b0, 1'b0, 0, 0, 0);
        expect_op("t3b", 1'b1, 8'd4, 8'd5, 14'd20, 1'b0, 1'b0, 0, 0, 0);
        expect_op("t3c", 1'b0, 8'd3, 8'd10, 14'd30, 1'b0, 1'b0, 0, 0, 0);
        expect_op("t3d", 1'b1, 8'd4, 8'd5, 14'd20, 1'b0, 1'b0, 0, 0, 0);
        req0 = 1'b0; req1 = 1'b0;

        // Zero product and a negative product.
        req1 = 1'b1; a1 = 8'd0; b1 = 8'd77;
        expect_op("t4", 1'b1, 8'd0, 8'd77, 14'd0, 1'b0, 1'b1, 1, 0, 0);
        req0 = 1'b1; a0 = 8'h85; b0 = 8'h06;
        expect_op("t4s", 1'b0, 8'h85, 8'h06, 14'd30, 1'b1, 1'b0, 1, 0, 0);

        // Operand change after grant has no effect.
        req0 = 1'b1; a0 = 8'd3; b0 = 8'd10;
        expect_op("t5", 1'b0, 8'd3, 8'd10, 14'd30, 1'b0, 1'b0, 1, 1, 0);

        // Asynchronous reset in the middle of WAIT.
        req0 = 1'b1; a0 = 8'd3; b0 = 8'd10;
        @(negedge clock);
        chk("t6_gnt", gnt0, 1'b1);
        req0 = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1 chk_zero("t6_async");
        @(negedge clock);
        reset = 1'b0;
        prev_res = '0;
        for (int i = 0; i < L + 3; i++) begin
            @(negedge clock);
            chk("t6_quiet", {out_valid, busy, gnt0, gnt1}, 0);
        end
        req0 = 1'b1;
        expect_op("t6", 1'b0, 8'd3, 8'd10, 14'd30, 1'b0, 1'b0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
